// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Start/Done controller in front of the ALU; runs single-cycle ops
//            through the ALU and performs DIV as a WIDTH-step restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic             Zero,
  output logic             DivByZero,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [2:0]       AluOp,
  input  logic [WIDTH-1:0] AluOut1
);

  localparam int         c_CW       = $clog2(WIDTH);
  localparam logic [2:0] c_OP_ADD   = 3'b010;
  localparam logic [2:0] c_OP_DIV   = 3'b101;
  localparam logic [2:0] c_OP_SHL   = 3'b110;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            state_next;
  logic [2:0]        r_op;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [c_CW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_d;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_out1;
  logic [WIDTH-1:0]  r_out2;
  logic              r_zero;
  logic              r_dbz;

  logic              w_op_valid;
  logic [WIDTH:0]    w_rshift;
  logic              w_ge;
  logic [WIDTH-1:0]  w_rnext;
  logic [WIDTH-1:0]  w_qnext;

  assign w_op_valid = (r_op >= c_OP_ADD) && (r_op <= c_OP_SHL);

  // One restoring step. The remainder stays below the divisor, so the
  // subtracted value always fits back into WIDTH bits.
  assign w_rshift = {r_rem, r_d[WIDTH-1]};
  assign w_ge     = (w_rshift >= {1'b0, r_b});
  assign w_rnext  = w_ge ? (w_rshift[WIDTH-1:0] - r_b) : w_rshift[WIDTH-1:0];
  assign w_qnext  = {r_q[WIDTH-2:0], w_ge};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= state_next;
    end
  end

  always_comb begin
    state_next = r_state;
    Busy       = 1'b1;
    Done       = 1'b0;
    AluOp      = 3'b000;
    case (r_state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Start) begin
          state_next = ((OP == c_OP_DIV) && (InputB != '0)) ? S_DIV : S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_op_valid) begin
          AluOp = r_op;
        end
        state_next = S_DONE;
      end
      S_DIV: begin
        if (r_cnt == c_CNT_LAST) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        Done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_op   <= 3'b000;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_d    <= '0;
      r_q    <= '0;
      r_out1 <= '0;
      r_out2 <= '0;
      r_zero <= 1'b1;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_op  <= OP;
            r_a   <= InputA;
            r_b   <= InputB;
            r_cnt <= '0;
            r_rem <= '0;
            r_d   <= InputA;
            r_q   <= '0;
          end
        end
        S_EXEC: begin
          // DIV only reaches EXEC when the divisor is zero.
          if (r_op == c_OP_DIV) begin
            r_out1 <= '1;
            r_out2 <= r_a;
            r_zero <= 1'b0;
            r_dbz  <= 1'b1;
          end else if (w_op_valid) begin
            r_out1 <= AluOut1;
            r_out2 <= '0;
            r_zero <= (AluOut1 == '0);
            r_dbz  <= 1'b0;
          end else begin
            r_out1 <= '0;
            r_out2 <= '0;
            r_zero <= 1'b1;
            r_dbz  <= 1'b0;
          end
        end
        S_DIV: begin
          r_rem <= w_rnext;
          r_d   <= {r_d[WIDTH-2:0], 1'b0};
          r_q   <= w_qnext;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            r_out1 <= w_qnext;
            r_out2 <= w_rnext;
            r_zero <= (w_qnext == '0);
            r_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Out1      = r_out1;
  assign Out2      = r_out2;
  assign Zero      = r_zero;
  assign DivByZero = r_dbz;
  assign AluA      = r_a;
  assign AluB      = r_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Vector table, corner-case sequences and randomized ops checked
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] SUB  = 3'b011;
  localparam logic [2:0] MULT = 3'b100;
  localparam logic [2:0] DIV  = 3'b101;
  localparam logic [2:0] SHL  = 3'b110;

  logic        Clk, Reset, Start;
  logic [2:0]  OP;
  logic [15:0] InputA, InputB;
  logic        Busy, Done, Zero, DivByZero;
  logic [15:0] Out1, Out2, AluA, AluB, AluOut1;
  logic [2:0]  AluOp;
  logic [31:0] prod;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] o1;
    logic [15:0] o2;
    logic        zero;
    logic        dbz;
    int          lat;
  } vec_t;

  alu_sequencer #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .OP(OP),
    .InputA(InputA), .InputB(InputB),
    .Busy(Busy), .Done(Done), .Out1(Out1), .Out2(Out2),
    .Zero(Zero), .DivByZero(DivByZero),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOut1(AluOut1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Combinational ALU the sequencer drives; unknown opcodes return a marker.
  always_comb begin
    prod = AluA * AluB;
    case (AluOp)
      ADD:     AluOut1 = AluA + AluB;
      SUB:     AluOut1 = AluA - AluB;
      MULT:    AluOut1 = prod[15:0];
      SHL:     AluOut1 = (AluB >= 16'd16) ? 16'h0000 : (AluA << AluB);
      default: AluOut1 = 16'hDEAD;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic vec_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    vec_t v;
    logic [31:0] p;
    v.op = op; v.a = a; v.b = b;
    v.o1 = 16'h0; v.o2 = 16'h0; v.dbz = 1'b0; v.lat = 2;
    p = a * b;
    case (op)
      ADD:  v.o1 = a + b;
      SUB:  v.o1 = a - b;
      MULT: v.o1 = p[15:0];
      SHL:  v.o1 = (b >= 16'd16) ? 16'h0 : 16'(a << b);
      DIV: begin
        if (b == 16'h0) begin
          v.o1 = 16'hFFFF; v.o2 = a; v.dbz = 1'b1;
        end else begin
          v.o1 = a / b; v.o2 = a % b; v.lat = 17;
        end
      end
      default: ;
    endcase
    v.zero = (v.o1 == 16'h0);
    return v;
  endfunction

  task automatic do_op(input vec_t v, input string tag);
    int lat;
    logic [2:0] exp_aluop;
    @(negedge Clk);
    Start = 1'b1; OP = v.op; InputA = v.a; InputB = v.b;
    @(negedge Clk);
    Start = 1'b0; OP = 3'($urandom); InputA = 16'($urandom); InputB = 16'($urandom);
    lat = 1;
    exp_aluop = ((v.op >= ADD) && (v.op <= SHL) && !((v.op == DIV) && (v.b != 16'h0))) ? v.op : 3'b000;
    chk({tag, " busy"},  32'(Busy), 32'(1));
    chk({tag, " aluop"}, 32'(AluOp), 32'(exp_aluop));
    chk({tag, " aluA"},  32'(AluA), 32'(v.a));
    chk({tag, " aluB"},  32'(AluB), 32'(v.b));
    while (!Done && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " out1"},    32'(Out1), 32'(v.o1));
    chk({tag, " out2"},    32'(Out2), 32'(v.o2));
    chk({tag, " zero"},    32'(Zero), 32'(v.zero));
    chk({tag, " dbz"},     32'(DivByZero), 32'(v.dbz));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " out1"},  32'(Out1), 32'(0));
    chk({tag, " out2"},  32'(Out2), 32'(0));
    chk({tag, " zero"},  32'(Zero), 32'(1));
    chk({tag, " done"},  32'(Done), 32'(0));
    chk({tag, " busy"},  32'(Busy), 32'(0));
    chk({tag, " dbz"},   32'(DivByZero), 32'(0));
    chk({tag, " aluop"}, 32'(AluOp), 32'(0));
    chk({tag, " aluA"},  32'(AluA), 32'(0));
    chk({tag, " aluB"},  32'(AluB), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [14];
    vec_t v;
    int ndone;
    int early_done;
    logic [2:0]  rop;
    logic [15:0] ra, rb;

    tbl[0]  = '{ADD,    16'h1234, 16'h0FFF, 16'h2233, 16'h0000, 1'b0, 1'b0, 2};
    tbl[1]  = '{SUB,    16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    tbl[2]  = '{MULT,   16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    tbl[3]  = '{DIV,    16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 17};
    tbl[4]  = '{DIV,    16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};
    tbl[5]  = '{DIV,    16'h0003, 16'h8000, 16'h0000, 16'h0003, 1'b1, 1'b0, 17};
    tbl[6]  = '{DIV,    16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 2};
    tbl[7]  = '{ADD,    16'h0001, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 2};
    tbl[8]  = '{SHL,    16'h0001, 16'h0004, 16'h0010, 16'h0000, 1'b0, 1'b0, 2};
    tbl[9]  = '{SHL,    16'h0001, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    tbl[10] = '{3'b111, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    tbl[11] = '{3'b000, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    tbl[12] = '{SUB,    16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 2};
    tbl[13] = '{MULT,   16'h0123, 16'h0456, 16'hEDC2, 16'h0000, 1'b0, 1'b0, 2};

    Reset = 1'b1; Start = 1'b0; OP = 3'b000; InputA = 16'h0; InputB = 16'h0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check_reset("reset");

    for (int i = 0; i < 14; i++) begin
      do_op(tbl[i], $sformatf("vec%0d", i));
    end

    // Start held high with changing operands across a DIV and its DONE cycle.
    @(negedge Clk);
    Start = 1'b1; OP = DIV; InputA = 16'd100; InputB = 16'd7;
    @(negedge Clk);
    OP = ADD; InputA = 16'd2; InputB = 16'd3;
    ndone = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k > 1) @(negedge Clk);
      if (Done) begin
        if (ndone == 0) begin
          chk("held first done cycle", 32'(k), 32'(17));
          chk("held first out1", 32'(Out1), 32'(14));
          chk("held first out2", 32'(Out2), 32'(2));
        end else if (ndone == 1) begin
          chk("held second done cycle", 32'(k), 32'(20));
          chk("held second out1", 32'(Out1), 32'(5));
          chk("held second out2", 32'(Out2), 32'(0));
        end
        ndone++;
      end
      if (k == 18 || k == 19) chk($sformatf("held out1 hold c%0d", k), 32'(Out1), 32'(14));
      if (k == 19) Start = 1'b0;
    end
    chk("held done count", 32'(ndone), 32'(2));

    // Reset in the middle of a division discards it.
    do_op(tbl[6], "pre-reset div0");
    @(negedge Clk);
    Start = 1'b1; OP = DIV; InputA = 16'h1234; InputB = 16'h0007;
    @(negedge Clk);
    Start = 1'b0;
    early_done = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge Clk);
      if (Done) early_done++;
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_reset("mid-div reset");
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (Done || Busy) early_done++;
    end
    chk("mid-div no done", 32'(early_done), 32'(0));
    do_op(tbl[8], "post-reset shl");

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 300; i++) begin
      rop = 3'($urandom);
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (rop == SHL) rb = 16'($urandom_range(0, 20));
      if (rop == DIV) begin
        case ($urandom_range(0, 3))
          0:       rb = 16'h0;
          1:       rb = 16'($urandom_range(1, 15));
          default: ;
        endcase
      end
      v = model(rop, ra, rb);
      do_op(v, $sformatf("rnd%0d op%0d", i, rop));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller in front of the combinational ALU. Accepts one operation per Start/Done handshake, drives the ALU for single-cycle ops (ADD, SUB, MULT, SHL) and registers its result. Executes DIV itself as a 16-iteration restoring divider producing quotient and remainder. Sits between the processor control path and the ALU; its registered Out1/Out2/Zero replace the ALU outputs at the register-file writeback mux.

## Interface

- WIDTH, 16, operand/result width; the divider runs WIDTH iterations.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only when Busy=0.
- OP  in  3  opcode: 010 ADD, 011 SUB, 100 MULT, 101 DIV, 110 SHL; others invalid.
- InputA  in  WIDTH  operand A (dividend), latched on accept.
- InputB  in  WIDTH  operand B (divisor/shift amount), latched on accept.
- Busy  out  1  high whenever state ≠ IDLE.
- Done  out  1  one-cycle pulse; results valid from this cycle on.
- Out1  out  WIDTH  result / quotient, held until next Done.
- Out2  out  WIDTH  remainder for DIV; 0 for all other ops.
- Zero  out  1  registered (Out1 == 0), updates with Out1.
- DivByZero  out  1  set with Done for DIV with InputB=0; cleared on next Done.
- AluA, AluB  out  WIDTH  latched operands to ALU.
- AluOp  out  3  latched OP in EXEC; 000 in every other state.
- AluOut1  in  WIDTH  ALU result; AluOut2 and AluZero are not used.

## Operation

- States: IDLE, EXEC, DIV, DONE.
- IDLE: Start=1 latches OP/InputA/InputB. Non-DIV op or DIV with InputB=0 → EXEC. DIV with InputB≠0 → DIV with counter=0, partial remainder R=0 (WIDTH+1 bits), shift register D=InputA, Q=0.
- EXEC (1 cycle): AluOp driven. On exit edge, capture Out1=AluOut1 for valid ops and Out2=0. Invalid op: Out1=0, Out2=0. DIV by zero: Out1=all ones, Out2=InputA, DivByZero=1. → DONE.
- DIV (WIDTH cycles), per cycle: R'={R[WIDTH-1:0], D[WIDTH-1]}; D<<=1; if R' ≥ {0,B} then R=R'−B, Q={Q,1}, else R=R', Q={Q,0}; counter+1. After counter reaches WIDTH−1, capture Out1=Q(final), Out2=R[WIDTH-1:0] → DONE.
- DONE (1 cycle): Done=1, Busy=1; Start ignored. → IDLE.
- Arithmetic: ADD/SUB wrap mod 2^WIDTH. MULT keeps the low WIDTH bits. SHL with InputB ≥ WIDTH gives 0 (ALU behaviour; registered unchanged).
- Start while Busy=1 is ignored, not queued; operand changes after accept have no effect.
- Reset (any state, including mid-DIV): next edge → IDLE. Out1=0, Out2=0, Zero=1, Done=0, Busy=0, DivByZero=0, AluOp=000, AluA=AluB=0, counter=0. A partial division is discarded and produces no Done.

## Timing

- Start accepted at edge of cycle N.
- Single-cycle ops, invalid ops, DIV by zero: EXEC in N+1; Done/results in N+2; IDLE in N+3, when the earliest next accept occurs.
- DIV, B≠0: DIV in cycles N+1..N+WIDTH; Done in N+WIDTH+1 (N+17 for WIDTH=16); next accept at N+WIDTH+2.
- Out1, Out2, Zero and DivByZero change only on the edge entering DONE, or on reset.
- No combinational path from Start/InputA/InputB to any output. The AluA/AluB/AluOp→AluOut1 path lies within one cycle.

## Test plan

- ADD 0x1234+0x0FFF at N → Done at N+2 only, Out1=0x2233, Out2=0, Zero=0; SUB 0x0005−0x0005 → Out1=0, Zero=1; MULT 0x0100*0x0100 → Out1=0x0000, Zero=1.
- DIV 100/7 at N → Busy N+1..N+17, Done at N+17, Out1=14, Out2=2; DIV 0xFFFF/0x0001 → Out1=0xFFFF, Out2=0; DIV 0x0003/0x8000 → Out1=0, Out2=3.
- DIV 0x1234/0 → Done at N+2, Out1=0xFFFF, Out2=0x1234, DivByZero=1; next ADD 1+1 → Out1=2, DivByZero=0.
- Start held high with new operands during a DIV and in DONE → only the first op completes; second accepted at N+18, Done at N+20.
- Reset asserted at N+8 of a DIV → IDLE next cycle, no Done, all outputs at reset values. A fresh SHL 0x0001<<4 → Out1=0x0010.
- Invalid OP 111 with InputA=0xAAAA → Done at N+2, Out1=0, Out2=0, Zero=1, AluOp=000 throughout.
